ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative 32x32 multiply/divide unit for the EX stage.
// A multiply is a 32-step shift-add on unsigned magnitudes. A divide is a
// 32-step restoring division. A final FIX cycle restores the signs and loads
// HI/LO. A divide by zero is resolved in one DIVZ cycle.
module ex_muldiv (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rsdata_i,
    input  logic [31:0] rtdata_i,
    input  logic        flush_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DIVZ} state_t;

    state_t      state_q;
    logic        is_div_q;     // op[1]: 1 = DIV/DIVU
    logic        sa_q;         // operand A was negative (signed ops only)
    logic        sb_q;         // operand B was negative (signed ops only)
    logic [31:0] a_q;          // |A|; shifts left into the quotient on divide
    logic [31:0] b_q;          // |B|; shifts right as the multiplier on multiply
    logic [63:0] acc_q;        // product accumulator / partial remainder in [32:0]
    logic [5:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Operand capture: take magnitudes for signed ops so the core works unsigned.
    logic        signed_op;
    logic        sa_d;
    logic        sb_d;
    logic [31:0] a_d;
    logic [31:0] b_d;

    // One iteration of each algorithm, plus the sign-corrected results.
    logic [32:0] mul_sum;
    logic [63:0] mul_acc_d;
    logic [32:0] div_sh;
    logic [33:0] div_trial;
    logic        div_ok;
    logic [32:0] div_rem_d;
    logic [31:0] div_quo_d;
    logic [63:0] fix_prod;
    logic [31:0] fix_quo;
    logic [31:0] fix_rem;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic [31:0] divz_hi;

    // Launch decode: sign flags and absolute operand values.
    always_comb begin
        signed_op = ~op_i[0];
        sa_d      = signed_op & rsdata_i[31];
        sb_d      = signed_op & rtdata_i[31];
        a_d       = sa_d ? (32'd0 - rsdata_i) : rsdata_i;
        b_d       = sb_d ? (32'd0 - rtdata_i) : rtdata_i;
    end

    // Datapath: one shift-add / restoring step and the FIX-stage sign fix-up.
    always_comb begin
        // Shift-add: add |A| into the upper half when the multiplier LSB is set,
        // then shift the whole accumulator right by one.
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
        mul_acc_d = {mul_sum, acc_q[31:1]};

        // Restoring step: bring in the next dividend bit (MSB first), trial-subtract.
        div_sh    = {acc_q[31:0], a_q[31]};
        div_trial = {1'b0, div_sh} - {2'b00, b_q};
        div_ok    = ~div_trial[33];
        div_rem_d = div_ok ? div_trial[32:0] : div_sh;
        div_quo_d = {a_q[30:0], div_ok};

        // Sign correction; flags are zero for unsigned ops so they pass through.
        fix_prod  = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
        fix_quo   = (sa_q ^ sb_q) ? (32'd0 - a_q) : a_q;
        fix_rem   = sa_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        fix_hi    = is_div_q ? fix_rem : fix_prod[63:32];
        fix_lo    = is_div_q ? fix_quo : fix_prod[31:0];

        // A divide by zero reports the original dividend, so undo the abs().
        divz_hi   = sa_q ? (32'd0 - a_q) : a_q;
    end

    // Control FSM with the iterative datapath and registered HI/LO/done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                // Squash wins over launch and over completion; HI/LO untouched.
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            is_div_q <= op_i[1];
                            sa_q     <= sa_d;
                            sb_q     <= sb_d;
                            a_q      <= a_d;
                            b_q      <= b_d;
                            acc_q    <= 64'd0;
                            cnt_q    <= 6'd0;
                            state_q  <= (op_i[1] && (rtdata_i == 32'd0)) ? DIVZ : CALC;
                        end
                    end
                    CALC: begin
                        if (is_div_q) begin
                            acc_q <= {31'd0, div_rem_d};
                            a_q   <= div_quo_d;
                        end else begin
                            acc_q <= mul_acc_d;
                            b_q   <= {1'b0, b_q[31:1]};
                        end
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    DIVZ: begin
                        hi_q    <= divz_hi;
                        lo_q    <= 32'hFFFF_FFFF;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o = (state_q != IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, randomized ops
// against an arithmetic reference model, and flush/reset/ignored-start sequences.
module tb_ex_muldiv;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rsdata_i;
    logic [31:0] rtdata_i;
    logic        flush_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        done_o;

    int n_chk  = 0;
    int n_fail = 0;

    ex_muldiv dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rsdata_i (rsdata_i),
        .rtdata_i (rtdata_i),
        .flush_i  (flush_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a) & 64'hFFFF_FFFF;
        ub = longint'(b) & 64'hFFFF_FFFF;
        case (op)
            2'b00: begin
                p = sa * sb;
                return p;
            end
            2'b01: begin
                return ua * ub;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op and watch 40 cycles; c=1 is the cycle after the start edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int busy_cnt, output int done_cyc, output int done_cnt);
        hi = 32'hDEAD_BEEF;
        lo = 32'hDEAD_BEEF;
        busy_cnt = 0;
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk_i);
        op_i = op; rsdata_i = a; rtdata_i = b; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        rsdata_i = $urandom;   // operands must already be latched
        rtdata_i = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    hi = hi_o;
                    lo = lo_o;
                end
            end
            @(negedge clk_i);
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] hi, lo, prev_hi, prev_lo;
    logic [63:0] exp;
    int          bc, dc, dn;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00;
        rsdata_i = 32'd0; rtdata_i = 32'd0; flush_i = 1'b0;

        vecs.push_back('{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003});
        vecs.push_back('{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});

        // Reset state
        #12;
        chk("reset_hi", hi_o, 32'd0);
        chk("reset_lo", lo_o, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_done", {31'd0, done_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, bc, dc, dn);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("vec%0d_done_cnt", i), 32'(dn), 32'd1);
            if (vecs[i].op[1] && vecs[i].b == 32'd0) begin
                chk($sformatf("vec%0d_busy_cyc", i), 32'(bc), 32'd1);
                chk($sformatf("vec%0d_done_at", i), 32'(dc), 32'd2);
            end else begin
                chk($sformatf("vec%0d_busy_cyc", i), 32'(bc), 32'd33);
                chk($sformatf("vec%0d_done_at", i), 32'(dc), 32'd34);
            end
        end

        // Randomized ops against the model
        for (int k = 0; k < 30; k++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            exp = model(rop, ra, rb);
            do_op(rop, ra, rb, hi, lo, bc, dc, dn);
            chk($sformatf("rnd%0d_op%0d_hi", k, rop), hi, exp[63:32]);
            chk($sformatf("rnd%0d_op%0d_lo", k, rop), lo, exp[31:0]);
            chk($sformatf("rnd%0d_done_at", k), 32'(dc),
                (rop[1] && rb == 32'd0) ? 32'd2 : 32'd34);
        end

        // Flush mid-operation: no completion, HI/LO keep prior values
        prev_hi = hi_o;
        prev_lo = lo_o;
        @(negedge clk_i);
        op_i = 2'b00; rsdata_i = 32'd5; rtdata_i = 32'd6; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (8) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_busy_low", {31'd0, busy_o}, 32'd0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) dn++;
            @(negedge clk_i);
        end
        chk("flush_no_done", 32'(dn), 32'd0);
        chk("flush_hi_kept", hi_o, prev_hi);
        chk("flush_lo_kept", lo_o, prev_lo);

        // Flush beats a simultaneous start
        op_i = 2'b01; rsdata_i = 32'd3; rtdata_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_vs_start_busy", {31'd0, busy_o}, 32'd0);

        // Normal op after flush
        do_op(2'b00, 32'd5, 32'd6, hi, lo, bc, dc, dn);
        chk("after_flush_lo", lo, 32'd30);
        chk("after_flush_hi", hi, 32'd0);
        chk("after_flush_done_at", 32'(dc), 32'd34);

        // Reset mid-operation: outputs clear immediately, nothing completes
        @(negedge clk_i);
        op_i = 2'b11; rsdata_i = 32'd100; rtdata_i = 32'd7; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (18) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o || busy_o) dn++;
            @(negedge clk_i);
        end
        chk("midrst_quiet", 32'(dn), 32'd0);

        // Start on the first edge after reset release; a second start while busy is ignored
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        op_i = 2'b11; rsdata_i = 32'd100; rtdata_i = 32'd7; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("first_edge_accept", {31'd0, busy_o}, 32'd1);
        dc = -1; dn = 0; hi = 32'hDEAD_BEEF; lo = 32'hDEAD_BEEF;
        for (int c = 1; c <= 40; c++) begin
            if (done_o) begin
                dn++;
                if (dc < 0) begin dc = c; hi = hi_o; lo = lo_o; end
            end
            if (c == 5) begin
                op_i = 2'b11; rsdata_i = 32'd9; rtdata_i = 32'd0; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        chk("ignored_start_done_cnt", 32'(dn), 32'd1);
        chk("ignored_start_done_at", 32'(dc), 32'd34);
        chk("ignored_start_hi", hi, 32'd2);
        chk("ignored_start_lo", lo, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
